// File: rtl/ccm_ctr_xor_buf.sv
`default_nettype none
// ============================================================================
// Module   : ccm_ctr_xor_buf
// Purpose  : Buffers CCM payload blocks, requests one keystream block per
//            payload, and XORs the returned keystream with the oldest payload.
// Revision : 1.0 - initial release
// ============================================================================
module ccm_ctr_xor_buf #(
  parameter int WIDTH_DATA = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_DATA-1:0] data_in,
  input  logic                  data_in_en,
  input  logic                  data_in_last,
  input  logic [4:0]            data_in_bytes,
  output logic                  data_in_ready,
  output logic                  input_en_buf,
  input  logic [WIDTH_DATA-1:0] encrypt_data,
  input  logic                  encrypt_en,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic                  data_out_en,
  output logic                  data_out_last,
  output logic                  msg_done,
  output logic                  err_ovf,
  output logic                  err_unf
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH_DATA-1:0] r_mem_data  [FIFO_DEPTH];
  logic [4:0]            r_mem_bytes [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;

  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_last;
  logic [4:0]            w_head_bytes;
  logic [WIDTH_DATA-1:0] w_mask;

  assign w_ready       = (r_state != S_DRAIN) && (r_count < c_FULL);
  assign data_in_ready = w_ready;
  assign w_push        = data_in_en && w_ready;
  assign w_pop         = encrypt_en && (r_count != '0);
  assign w_head_last   = r_mem_last[r_rd_ptr];
  assign w_head_bytes  = r_mem_bytes[r_rd_ptr];

  // A partial last block keeps only its N most-significant bytes.
  always_comb begin
    w_mask = {WIDTH_DATA{1'b1}};
    if (w_head_last && (w_head_bytes != 5'd0))
      w_mask = ~({WIDTH_DATA{1'b1}} >> {w_head_bytes, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= data_in;
      r_mem_bytes[r_wr_ptr] <= data_in_bytes;
      r_mem_last[r_wr_ptr]  <= data_in_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_push) w_state_next = data_in_last ? S_DRAIN : S_RUN;
      S_RUN:   if (w_push && data_in_last) w_state_next = S_DRAIN;
      // Leave only after the final block has actually been presented.
      S_DRAIN: if ((r_count == '0) && data_out_en && data_out_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      input_en_buf  <= 1'b0;
      data_out      <= '0;
      data_out_en   <= 1'b0;
      data_out_last <= 1'b0;
      msg_done      <= 1'b0;
      err_ovf       <= 1'b0;
      err_unf       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      input_en_buf  <= w_push;
      data_out_en   <= w_pop;
      data_out_last <= w_pop && w_head_last;
      msg_done      <= (r_state == S_DRAIN) && (w_state_next == S_IDLE);
      if (w_pop)                        data_out <= (r_mem_data[r_rd_ptr] ^ encrypt_data) & w_mask;
      if (data_in_en && !w_ready)       err_ovf  <= 1'b1;
      if (encrypt_en && r_count == '0)  err_unf  <= 1'b1;
    end
  end

endmodule
`default_nettype wire
